// File: rtl/handshake_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// handshake_ctrl_pkg
// Shared types for the two-phase micropipeline stage controller.
//   hs_state_e : controller FSM state (IDLE, COUNT)
//   CNT_W      : width of the matched-delay counter
//   hs_cnt_t   : matched-delay counter type
// -----------------------------------------------------------------------------
package handshake_ctrl_pkg;

   typedef enum logic {IDLE, COUNT} hs_state_e;

   localparam int unsigned CNT_W = 16;

   typedef logic [CNT_W-1:0] hs_cnt_t;

endpackage : handshake_ctrl_pkg

// File: rtl/hs_sync_2ff.sv
// -----------------------------------------------------------------------------
// hs_sync_2ff
// Generic two-flop synchroniser for a single-bit level, synchronous
// active-low reset to 0.
// Ports:
//   i_clk   : destination clock
//   i_rst_n : synchronous active-low reset
//   i_d     : asynchronous input level
//   o_q     : synchronised level (two cycles of latency)
// -----------------------------------------------------------------------------
module hs_sync_2ff (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule : hs_sync_2ff

// File: rtl/handshake_ctrl.sv
// -----------------------------------------------------------------------------
// handshake_ctrl
// Two-phase (transition-signalling) micropipeline stage controller. A token
// arriving on req_in_i is committed when the stage is free, held for a
// matched delay of DELAY cycles, then forwarded downstream (req_out_o) and
// acknowledged upstream (ack_in_o) on the same edge.
// Parameters:
//   DELAY     : matched delay in cycles, 0..65535
// Ports:
//   clk_i     : clock, rising edge
//   rst_ni    : synchronous active-low reset
//   req_in_i  : upstream request (two-phase)
//   ack_out_i : downstream acknowledge (two-phase)
//   req_out_o : downstream request (two-phase, registered)
//   ack_in_o  : upstream acknowledge (two-phase, registered)
// Build option:
//   HANDSHAKE_CTRL_SYNC_INPUTS_EN : pass req_in_i/ack_out_i through 2-flop
//   synchronisers (adds 2 cycles to every latency).
// -----------------------------------------------------------------------------
module handshake_ctrl
   import handshake_ctrl_pkg::*;
#(
   parameter int unsigned DELAY = 25
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic req_in_i,
   input  logic ack_out_i,
   output logic req_out_o,
   output logic ack_in_o
);

   localparam bit      ZERO_DELAY = (DELAY == 0);
   localparam hs_cnt_t LOAD_VAL   = ZERO_DELAY ? '0 : hs_cnt_t'(DELAY - 1);

   logic w_req_in;
   logic w_ack_out;

`ifdef HANDSHAKE_CTRL_SYNC_INPUTS_EN
   hs_sync_2ff u_sync_req (
      .i_clk   (clk_i),
      .i_rst_n (rst_ni),
      .i_d     (req_in_i),
      .o_q     (w_req_in)
   );

   hs_sync_2ff u_sync_ack (
      .i_clk   (clk_i),
      .i_rst_n (rst_ni),
      .i_d     (ack_out_i),
      .o_q     (w_ack_out)
   );
`else
   assign w_req_in  = req_in_i;
   assign w_ack_out = ack_out_i;
`endif

   hs_state_e r_state;
   hs_cnt_t   r_cnt;
   logic      r_req_out;
   logic      r_ack_in;

   logic w_pending;
   logic w_free;
   logic w_commit;

   // Two-phase rule: an unmatched transition on one side is an open token.
   assign w_pending = (w_req_in != r_ack_in);
   assign w_free    = (w_ack_out == r_req_out);
   assign w_commit  = (r_state == IDLE) && w_pending && w_free;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_req_out <= 1'b0;
         r_ack_in  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_commit) begin
                  if (ZERO_DELAY) begin
                     r_req_out <= ~r_req_out;
                     r_ack_in  <= ~r_ack_in;
                  end else begin
                     r_cnt   <= LOAD_VAL;
                     r_state <= COUNT;
                  end
               end
            end
            COUNT: begin
               // Committed token always fires; inputs are ignored here.
               if (r_cnt == '0) begin
                  r_req_out <= ~r_req_out;
                  r_ack_in  <= ~r_ack_in;
                  r_state   <= IDLE;
               end else begin
                  r_cnt <= r_cnt - hs_cnt_t'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign req_out_o = r_req_out;
   assign ack_in_o  = r_ack_in;

   // A downstream ack transition is only legal while a forwarded token is
   // outstanding (previous ack differs from req_out).
   property p_no_spurious_ack;
      @(posedge clk_i) disable iff (!rst_ni)
         $changed(w_ack_out) |-> ($past(w_ack_out) != r_req_out);
   endproperty

   a_no_spurious_ack : assert property (p_no_spurious_ack);

endmodule : handshake_ctrl

// File: tb/tb_handshake_ctrl.sv
// -----------------------------------------------------------------------------
// tb_handshake_ctrl
// Directed bench for handshake_ctrl (default build, inputs unsynchronised).
// Instances: u_dut (DELAY=25), u_c1/u_c2 chain (DELAY=25 -> DELAY=15),
// u_z (DELAY=0). Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_handshake_ctrl;

   logic clk = 1'b0;
   logic rst_n;

   logic req, ack, ro, ai;
   logic creq, c1_ro, c1_ai, c2_ro, c2_ai, c2_ack;
   logic zreq, zack, z_ro, z_ai;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   handshake_ctrl #(.DELAY(25)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .req_in_i(req), .ack_out_i(ack),
      .req_out_o(ro), .ack_in_o(ai));

   handshake_ctrl #(.DELAY(25)) u_c1 (
      .clk_i(clk), .rst_ni(rst_n), .req_in_i(creq), .ack_out_i(c2_ai),
      .req_out_o(c1_ro), .ack_in_o(c1_ai));

   handshake_ctrl #(.DELAY(15)) u_c2 (
      .clk_i(clk), .rst_ni(rst_n), .req_in_i(c1_ro), .ack_out_i(c2_ack),
      .req_out_o(c2_ro), .ack_in_o(c2_ai));

   handshake_ctrl #(.DELAY(0)) u_z (
      .clk_i(clk), .rst_ni(rst_n), .req_in_i(zreq), .ack_out_i(zack),
      .req_out_o(z_ro), .ack_in_o(z_ai));

   typedef struct {
      logic       rst;
      logic       rq;
      logic       ak;
      logic [1:0] exp;   // {req_out, ack_in}
   } vec_t;

   vec_t tbl[11];

   function automatic logic [1:0] get(input int sel);
      case (sel)
         0:       return {ro, ai};
         1:       return {c1_ro, c1_ai};
         2:       return {c2_ro, c2_ai};
         default: return {z_ro, z_ai};
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [1:0] act, input logic [1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got {req_out,ack_in}=%b expected %b at t=%0t", nm, act, exp, $time);
      end
   endtask

   // n edges during which the selected outputs must stay at exp
   task automatic hold(input string nm, input int sel, input int n, input logic [1:0] exp);
      logic [1:0] seen;
      seen = exp;
      for (int i = 0; i < n; i++) begin
         tick();
         if (get(sel) !== exp) seen = get(sel);
      end
      check(nm, seen, exp);
   endtask

   task automatic step_check(input string nm, input int sel, input logic [1:0] exp);
      tick();
      check(nm, get(sel), exp);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req = 1'b0; ack = 1'b0; creq = 1'b0; c2_ack = 1'b0;
      zreq = 1'b0; zack = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      req = 1'b0; ack = 1'b0; creq = 1'b0; c2_ack = 1'b0;
      zreq = 1'b0; zack = 1'b0;

      // DELAY=0: {rst, req, ack, expected {req_out, ack_in}}
      tbl[0]  = '{1'b0, 1'b1, 1'b0, 2'b00};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 2'b00};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 2'b11};
      tbl[3]  = '{1'b1, 1'b1, 1'b1, 2'b11};
      tbl[4]  = '{1'b1, 1'b0, 1'b1, 2'b00};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 2'b00};
      tbl[6]  = '{1'b1, 1'b1, 1'b0, 2'b11};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 2'b11};
      tbl[8]  = '{1'b1, 1'b0, 1'b1, 2'b00};
      tbl[9]  = '{1'b1, 1'b0, 1'b0, 2'b00};
      tbl[10] = '{1'b1, 1'b0, 1'b0, 2'b00};

      // Reset held with a pending request, then the token fires 26 edges on
      req = 1'b1;
      hold("rst_hold", 0, 3, 2'b00);
      rst_n = 1'b1;
      hold("rst_wait", 0, 25, 2'b00);
      step_check("rst_fire", 0, 2'b11);

      // Single token
      do_reset();
      req = 1'b1;
      hold("single_wait", 0, 25, 2'b00);
      step_check("single_fire", 0, 2'b11);
      hold("single_quiet", 0, 10, 2'b11);

      // Pulse 0->1->0: two tokens, second waits for downstream ack
      do_reset();
      req = 1'b1;
      tick();
      req = 1'b0;
      hold("pulse_wait1", 0, 24, 2'b00);
      step_check("pulse_fire1", 0, 2'b11);
      hold("pulse_stall", 0, 10, 2'b11);
      ack = 1'b1;
      hold("pulse_wait2", 0, 25, 2'b11);
      step_check("pulse_fire2", 0, 2'b00);
      hold("pulse_quiet", 0, 5, 2'b00);

      // Two-stage chain
      do_reset();
      creq = 1'b1;
      hold("chain_s1_wait", 1, 25, 2'b00);
      step_check("chain_s1_fire", 1, 2'b11);
      hold("chain_s2_wait", 2, 15, 2'b00);
      step_check("chain_s2_fire", 2, 2'b11);
      hold("chain_s1_quiet", 1, 5, 2'b11);
      hold("chain_s2_quiet", 2, 5, 2'b11);

      // DELAY=0 table
      for (int unsigned i = 0; i < 11; i++) begin
         rst_n = tbl[i].rst;
         zreq  = tbl[i].rq;
         zack  = tbl[i].ak;
         tick();
         check($sformatf("zero_delay[%0d]", i), get(3), tbl[i].exp);
      end

      // Reset mid-count aborts, a fresh token then takes the full latency
      do_reset();
      req = 1'b1;
      hold("abort_count", 0, 10, 2'b00);
      rst_n = 1'b0;
      req = 1'b0;
      step_check("abort_rst", 0, 2'b00);
      tick();
      rst_n = 1'b1;
      hold("abort_nofire", 0, 30, 2'b00);
      req = 1'b1;
      hold("abort_rewait", 0, 25, 2'b00);
      step_check("abort_refire", 0, 2'b11);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_handshake_ctrl
